mdom_wvb_hdr_fifo: RTL and testbench
====================================

# mdom_wvb_hdr_fifo

Parametrised successor to the waveform-buffer header fan-in. It captures one header (event LTC, start/stop address, trigger source, constant-run flag, pre-trigger config) per write strobe and packs it into a single header bundle word. It buffers up to DEPTH headers in a show-ahead FIFO, with occupancy, almost-full, and sticky overflow/drop accounting. It sits between the per-channel waveform-buffer write controller and the readout/transfer logic.

## Interface

- P_LTC_W, 48, event LTC width
- P_ADR_W, 12, waveform buffer address width (start and stop)
- P_TRIG_W, 2, trigger source width
- P_PRE_W, 5, pre-trigger config width
- P_DEPTH, 16, header FIFO depth; power of two, at least 2
- P_AFULL, 12, almost_full threshold; 1 to P_DEPTH
- Derived: P_BW = P_LTC_W + 2*P_ADR_W + P_TRIG_W + 1 + P_PRE_W (80 at defaults); P_AW = log2(P_DEPTH)
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  header write strobe, one header per high cycle
- evt_ltc  in  P_LTC_W  event LTC
- start_addr  in  P_ADR_W  first waveform address
- stop_addr  in  P_ADR_W  last waveform address
- trig_src  in  P_TRIG_W  trigger source
- cnst_run  in  1  constant-run flag
- pre_conf  in  P_PRE_W  pre-trigger configuration
- rd_en  in  1  pop the head entry; honoured only while hdr_valid=1
- clr_ovf  in  1  clears overflow and drop_cnt
- hdr_bundle  out  P_BW  head entry (show-ahead)
- hdr_valid  out  1  FIFO not empty
- hdr_count  out  P_AW+1  entries stored, 0 to P_DEPTH
- almost_full  out  1  hdr_count >= P_AFULL
- full  out  1  hdr_count == P_DEPTH
- overflow  out  1  sticky: a header was dropped
- drop_cnt  out  16  dropped headers, saturating at 0xFFFF

## Operation

- Bundle packing, LSB first:
  - evt_ltc at [P_LTC_W-1:0]
  - then start_addr, stop_addr, trig_src, cnst_run
  - pre_conf in the top P_PRE_W bits
  - At defaults: [47:0] ltc, [59:48] start, [71:60] stop, [73:72] trig, [74] cnst_run, [79:75] pre_conf.
- Storage: P_DEPTH x P_BW array.
  - Write and read pointers are P_AW+1 bits. Their MSB distinguishes full from empty; the low P_AW bits wrap modulo P_DEPTH.
- Write accepted when wr_en=1 and either full=0, or full=1 with a pop in the same cycle.
- Pop occurs when rd_en=1 and hdr_valid=1. rd_en while empty is ignored; no pointer or count change.
- Simultaneous write and pop:
  - not empty: both happen, count unchanged;
  - empty: write only, count becomes 1;
  - full: both happen, no drop.
- Drop occurs on wr_en=1 while full=1 with no pop. Entry is not stored; overflow is set to 1; drop_cnt increments by 1, saturating at 0xFFFF.
- clr_ovf=1: overflow and drop_cnt clear. If a drop occurs in the same cycle, the drop wins over the clear: overflow=1, drop_cnt=1.
- hdr_count, full, almost_full, and hdr_valid are registered, consistent with the pointers after each edge.
- hdr_bundle is the memory word at the read pointer. Undefined content while hdr_valid=0; the bench must not check it then.

## Timing

- Reset (rst_n low, asynchronous): pointers=0, hdr_count=0, hdr_valid=0, full=0, almost_full=0 (P_AFULL>=1), overflow=0, drop_cnt=0. Memory contents are not reset.
- Write latency: header presented with wr_en at edge N. It is stored at N; hdr_valid, hdr_count, and hdr_bundle reflect it after edge N (visible in cycle N+1).
- Pop: rd_en sampled at edge N. The next entry appears on hdr_bundle in cycle N+1; hdr_valid drops after edge N if that was the last entry.
- Throughput: one write and one pop per cycle, sustained.
- Reset asserted mid-operation empties the FIFO immediately. No header written before reset is ever presented afterward.

## Test plan

- Reset, then 3 writes with ltc=0x1,0x2,0x3, start=0x010, stop=0x0FF, trig=2, cnst_run=1, pre_conf=0x15 -> hdr_count=3; hdr_bundle[47:0]=0x1, [59:48]=0x010, [71:60]=0x0FF, [73:72]=2, [74]=1, [79:75]=0x15. Three pops return ltc 1,2,3 in order, then hdr_valid=0.
- Fill 16 entries -> almost_full asserts after the 12th write, full after the 16th. A 17th write with no rd_en -> overflow=1, drop_cnt=1, hdr_count=16, head still ltc of entry 1.
- Full FIFO, wr_en and rd_en in the same cycle -> no drop, hdr_count=16, new entry read out 16th.
- Empty FIFO, rd_en alone -> no change. wr_en+rd_en together -> hdr_count=1, hdr_valid=1 next cycle.
- Force 0x10005 drops -> drop_cnt saturates at 0xFFFF. clr_ovf coincident with a drop -> overflow=1, drop_cnt=1.
- 40 random write/pop cycles (pointer wrap twice), rst_n pulsed low mid-stream -> outputs at reset values immediately; scoreboard order correct before and after reset.

Source files
------------

// File: rtl/mdom_wvb_hdr_fifo_if.sv
// Header write/readout bundle between the waveform-buffer write controller and the readout logic.
// master = producer/consumer side, slave = the header FIFO.
interface mdom_wvb_hdr_fifo_if #(
  parameter int unsigned P_LTC_W = 48,
  parameter int unsigned P_ADR_W = 12,
  parameter int unsigned P_TRIG_W = 2,
  parameter int unsigned P_PRE_W = 5,
  parameter int unsigned P_DEPTH = 16
);
  localparam int unsigned P_BW = P_LTC_W + 2 * P_ADR_W + P_TRIG_W + 1 + P_PRE_W;
  localparam int unsigned P_AW = $clog2(P_DEPTH);

  logic                wr_en;
  logic [P_LTC_W-1:0]  evt_ltc;
  logic [P_ADR_W-1:0]  start_addr;
  logic [P_ADR_W-1:0]  stop_addr;
  logic [P_TRIG_W-1:0] trig_src;
  logic                cnst_run;
  logic [P_PRE_W-1:0]  pre_conf;
  logic                rd_en;
  logic                clr_ovf;
  logic [P_BW-1:0]     hdr_bundle;
  logic                hdr_valid;
  logic [P_AW:0]       hdr_count;
  logic                almost_full;
  logic                full;
  logic                overflow;
  logic [15:0]         drop_cnt;

  modport master (
    output wr_en, evt_ltc, start_addr, stop_addr, trig_src, cnst_run, pre_conf,
    output rd_en, clr_ovf,
    input  hdr_bundle, hdr_valid, hdr_count, almost_full, full, overflow, drop_cnt
  );

  modport slave (
    input  wr_en, evt_ltc, start_addr, stop_addr, trig_src, cnst_run, pre_conf,
    input  rd_en, clr_ovf,
    output hdr_bundle, hdr_valid, hdr_count, almost_full, full, overflow, drop_cnt
  );
endinterface

// File: rtl/mdom_wvb_hdr_fifo.sv
// Waveform-buffer header fan-in: packs one header per write strobe into a bundle word and
// buffers it in a show-ahead FIFO with occupancy flags and sticky drop accounting.
module mdom_wvb_hdr_fifo #(
  parameter int unsigned P_LTC_W = 48,
  parameter int unsigned P_ADR_W = 12,
  parameter int unsigned P_TRIG_W = 2,
  parameter int unsigned P_PRE_W = 5,
  parameter int unsigned P_DEPTH = 16,
  parameter int unsigned P_AFULL = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mdom_wvb_hdr_fifo_if.slave   bus
);
  localparam int unsigned P_BW  = P_LTC_W + 2 * P_ADR_W + P_TRIG_W + 1 + P_PRE_W;
  localparam int unsigned P_AW  = $clog2(P_DEPTH);
  localparam int unsigned P_CW  = P_AW + 1;
  localparam int unsigned P_DCW = 16;

  logic [P_BW-1:0]  mem_q [P_DEPTH];
  logic [P_CW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [P_CW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [P_CW-1:0]  count_q, count_d;
  logic             valid_q, valid_d;
  logic             full_q, full_d;
  logic             afull_q, afull_d;
  logic             ovf_q, ovf_d;
  logic [P_DCW-1:0] drop_q, drop_d;

  logic [P_BW-1:0]  wr_bundle_c;
  logic             pop_c;
  logic             push_c;
  logic             drop_c;

  assign wr_bundle_c = {bus.pre_conf, bus.cnst_run, bus.trig_src,
                        bus.stop_addr, bus.start_addr, bus.evt_ltc};

  // A write into a full FIFO is still accepted when the head leaves in the same cycle.
  assign pop_c  = bus.rd_en & valid_q;
  assign push_c = bus.wr_en & (~full_q | pop_c);
  assign drop_c = bus.wr_en & full_q & ~pop_c;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;

    if (push_c) wr_ptr_d = wr_ptr_q + P_CW'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + P_CW'(1);

    // Pointer distance modulo 2^(AW+1) is the occupancy, 0..P_DEPTH.
    count_d = wr_ptr_d - rd_ptr_d;
    valid_d = (count_d != '0);
    full_d  = (count_d == P_CW'(P_DEPTH));
    afull_d = (count_d >= P_CW'(P_AFULL));

    // A drop in the same cycle as a clear restarts the count at one.
    if (drop_c) begin
      ovf_d = 1'b1;
      if (bus.clr_ovf)        drop_d = P_DCW'(1);
      else if (drop_q != '1)  drop_d = drop_q + P_DCW'(1);
    end else if (bus.clr_ovf) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  // Header storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q[P_AW-1:0]] <= wr_bundle_c;
  end

  assign bus.hdr_bundle  = mem_q[rd_ptr_q[P_AW-1:0]];
  assign bus.hdr_valid   = valid_q;
  assign bus.hdr_count   = count_q;
  assign bus.almost_full = afull_q;
  assign bus.full        = full_q;
  assign bus.overflow    = ovf_q;
  assign bus.drop_cnt    = drop_q;
endmodule

// File: tb/tb_mdom_wvb_hdr_fifo.sv
// Self-checking bench for mdom_wvb_hdr_fifo: queue-based reference model compared every cycle,
// plus literal expectations at the key points of each directed scenario.
module tb_mdom_wvb_hdr_fifo;
  localparam int unsigned P_LTC_W = 48;
  localparam int unsigned P_ADR_W = 12;
  localparam int unsigned P_TRIG_W = 2;
  localparam int unsigned P_PRE_W = 5;
  localparam int unsigned P_DEPTH = 16;
  localparam int unsigned P_AFULL = 12;
  localparam int unsigned P_BW = P_LTC_W + 2 * P_ADR_W + P_TRIG_W + 1 + P_PRE_W;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  mdom_wvb_hdr_fifo_if #(
    .P_LTC_W(P_LTC_W), .P_ADR_W(P_ADR_W), .P_TRIG_W(P_TRIG_W),
    .P_PRE_W(P_PRE_W), .P_DEPTH(P_DEPTH)
  ) bus ();

  mdom_wvb_hdr_fifo #(
    .P_LTC_W(P_LTC_W), .P_ADR_W(P_ADR_W), .P_TRIG_W(P_TRIG_W),
    .P_PRE_W(P_PRE_W), .P_DEPTH(P_DEPTH), .P_AFULL(P_AFULL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: ordered list of stored headers plus drop accounting.
  logic [P_BW-1:0] mq[$];
  bit              m_ovf;
  int              m_drop;

  always @(posedge clk or negedge rst_n) begin
    bit pop, drop;
    logic [P_BW-1:0] hdr;
    if (!rst_n) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_drop = 0;
    end else begin
      hdr  = {bus.pre_conf, bus.cnst_run, bus.trig_src, bus.stop_addr, bus.start_addr, bus.evt_ltc};
      pop  = bus.rd_en && (mq.size() > 0);
      drop = bus.wr_en && (mq.size() == P_DEPTH) && !pop;
      if (pop) void'(mq.pop_front());
      if (bus.wr_en && !drop) mq.push_back(hdr);
      if (drop) begin
        m_ovf  = 1'b1;
        m_drop = bus.clr_ovf ? 1 : ((m_drop < 65535) ? m_drop + 1 : 65535);
      end else if (bus.clr_ovf) begin
        m_ovf  = 1'b0;
        m_drop = 0;
      end
    end
  end

  // Compare process, on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("hdr_count",   128'(bus.hdr_count),   128'(mq.size()));
      chk("hdr_valid",   128'(bus.hdr_valid),   128'(mq.size() != 0));
      chk("full",        128'(bus.full),        128'(mq.size() == P_DEPTH));
      chk("almost_full", 128'(bus.almost_full), 128'(mq.size() >= P_AFULL));
      chk("overflow",    128'(bus.overflow),    128'(m_ovf));
      chk("drop_cnt",    128'(bus.drop_cnt),    128'(m_drop));
      if (mq.size() != 0) chk("hdr_bundle", 128'(bus.hdr_bundle), 128'(mq[0]));
    end
  end

  task automatic set_hdr(input logic [47:0] ltc);
    bus.evt_ltc    = ltc;
    bus.start_addr = 12'h010;
    bus.stop_addr  = 12'h0FF;
    bus.trig_src   = 2'd2;
    bus.cnst_run   = 1'b1;
    bus.pre_conf   = 5'h15;
  endtask

  task automatic set_rand_hdr();
    bus.evt_ltc    = 48'({$urandom(), $urandom()});
    bus.start_addr = 12'($urandom());
    bus.stop_addr  = 12'($urandom());
    bus.trig_src   = 2'($urandom());
    bus.cnst_run   = 1'($urandom());
    bus.pre_conf   = 5'($urandom());
  endtask

  // Drive one cycle of strobes; returns just after the edge that samples them.
  task automatic step(input logic w, input logic r, input logic c);
    bus.wr_en   = w;
    bus.rd_en   = r;
    bus.clr_ovf = c;
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"}, 128'(bus.hdr_count),   128'(0));
    chk({tag, "_valid"}, 128'(bus.hdr_valid),   128'(0));
    chk({tag, "_full"},  128'(bus.full),        128'(0));
    chk({tag, "_afull"}, 128'(bus.almost_full), 128'(0));
    chk({tag, "_ovf"},   128'(bus.overflow),    128'(0));
    chk({tag, "_drop"},  128'(bus.drop_cnt),    128'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.clr_ovf = 1'b0;
    set_hdr(48'h0);
    repeat (3) @(posedge clk);
    #2;
    chk_reset_vals("rst");
    rst_n = 1'b1;
    step(0, 0, 0);

    // Three writes, check packing of the head, then drain in order.
    for (int i = 1; i <= 3; i++) begin
      set_hdr(48'(i));
      step(1, 0, 0);
    end
    step(0, 0, 0);
    chk("three_count", 128'(bus.hdr_count), 128'(3));
    chk("pk_ltc",   128'(bus.hdr_bundle[47:0]),  128'(48'h1));
    chk("pk_start", 128'(bus.hdr_bundle[59:48]), 128'(12'h010));
    chk("pk_stop",  128'(bus.hdr_bundle[71:60]), 128'(12'h0FF));
    chk("pk_trig",  128'(bus.hdr_bundle[73:72]), 128'(2'd2));
    chk("pk_cnst",  128'(bus.hdr_bundle[74]),    128'(1'b1));
    chk("pk_pre",   128'(bus.hdr_bundle[79:75]), 128'(5'h15));
    for (int i = 1; i <= 3; i++) begin
      chk("pop_order", 128'(bus.hdr_bundle[47:0]), 128'(i));
      step(0, 1, 0);
    end
    chk("drained_valid", 128'(bus.hdr_valid), 128'(0));

    // Fill to full, watching almost_full/full thresholds, then one dropped write.
    for (int i = 1; i <= 16; i++) begin
      set_hdr(48'h100 + 48'(i));
      step(1, 0, 0);
      chk("fill_afull", 128'(bus.almost_full), 128'(i >= 12));
      chk("fill_full",  128'(bus.full),        128'(i == 16));
    end
    set_hdr(48'h1FF);
    step(1, 0, 0);
    chk("ovf_set",    128'(bus.overflow),          128'(1));
    chk("ovf_drop",   128'(bus.drop_cnt),          128'(1));
    chk("ovf_count",  128'(bus.hdr_count),         128'(16));
    chk("ovf_head",   128'(bus.hdr_bundle[47:0]),  128'(48'h101));

    // Full with simultaneous write and pop: no drop, new entry comes out 16th.
    set_hdr(48'h200);
    step(1, 1, 0);
    chk("wrrd_full_count", 128'(bus.hdr_count), 128'(16));
    chk("wrrd_full_drop",  128'(bus.drop_cnt),  128'(1));
    for (int i = 0; i < 15; i++) step(0, 1, 0);
    chk("wrrd_full_last", 128'(bus.hdr_bundle[47:0]), 128'(48'h200));
    step(0, 1, 0);
    chk("wrrd_full_empty", 128'(bus.hdr_valid), 128'(0));

    // Empty: pop alone is ignored, write+pop stores one entry.
    step(0, 1, 0);
    chk("empty_rd_count", 128'(bus.hdr_count), 128'(0));
    set_hdr(48'h300);
    step(1, 1, 0);
    chk("empty_wrrd_count", 128'(bus.hdr_count), 128'(1));
    chk("empty_wrrd_valid", 128'(bus.hdr_valid), 128'(1));
    chk("empty_wrrd_head",  128'(bus.hdr_bundle[47:0]), 128'(48'h300));
    step(0, 1, 0);

    // Saturating drop counter, then clear coincident with a drop, then plain clear.
    step(0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      set_hdr(48'h400 + 48'(i));
      step(1, 0, 0);
    end
    for (int i = 0; i < 32'h10005; i++) step(1, 0, 0);
    chk("sat_drop", 128'(bus.drop_cnt), 128'(16'hFFFF));
    chk("sat_ovf",  128'(bus.overflow), 128'(1));
    step(1, 0, 1);
    chk("clr_drop_cnt", 128'(bus.drop_cnt), 128'(1));
    chk("clr_drop_ovf", 128'(bus.overflow), 128'(1));
    step(0, 0, 1);
    chk("clr_cnt", 128'(bus.drop_cnt), 128'(0));
    chk("clr_ovf", 128'(bus.overflow), 128'(0));
    chk("clr_head", 128'(bus.hdr_bundle[47:0]), 128'(48'h400));
    for (int i = 0; i < 16; i++) step(0, 1, 0);

    // Random traffic with a reset pulse in the middle.
    for (int i = 0; i < 40; i++) begin
      if (i == 20) begin
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.clr_ovf = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
      end else begin
        set_rand_hdr();
        step(1'(($urandom() % 8) != 0), 1'(($urandom() % 4) != 0), 1'b0);
      end
    end
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.clr_ovf = 1'b0;
    for (int i = 0; i < 20; i++) step(0, 1, 0);
    chk("final_empty", 128'(bus.hdr_valid), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
